uart_frame_reader: RTL and testbench

- Consumer stage directly downstream of the UART receiver and its 113-byte frame buffer RAM.
- The receiver raises re_in when a full frame sits in the buffer.
- This block reads the frame back from RAM, checks the sync byte and checksum, latches the command byte, and streams the payload bytes out with a valid/ready handshake.
- It ends each frame with a single-cycle frame_ok or frame_err.

---
 rtl/uart_frame_reader_if.sv | 22 ++
 rtl/uart_frame_reader.sv | 216 +++++++++++++++++++++
 tb/tb_uart_frame_reader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_reader_if.sv
// Payload stream from the frame reader: one byte per valid/ready handshake,
// with out_last tagging the final payload byte of a frame.
interface uart_frame_reader_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/uart_frame_reader.sv
// Reads a complete UART frame back from the receive buffer, checks sync and
// checksum, latches the command byte and streams the payload downstream.
module uart_frame_reader #(
    parameter int unsigned FRAME_LEN = 113,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                re_in,
    input  logic [7:0]          mem_data,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_en,
    output logic [7:0]          cmd,
    output logic                cmd_valid,
    uart_frame_reader_if.master out_if,
    output logic                frame_ok,
    output logic                frame_err,
    output logic [1:0]          err_code,
    output logic                busy
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN);

    localparam logic [IDX_W-1:0]  IDX_CMD      = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_PAY0     = IDX_W'(2);
    localparam logic [IDX_W-1:0]  IDX_LAST_PAY = IDX_W'(FRAME_LEN - 2);
    localparam logic [IDX_W-1:0]  IDX_CSUM     = IDX_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_TOP     = ADDR_W'(FRAME_LEN);

    localparam logic [1:0] ERR_SYNC    = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_OUT,
        S_CHECK
    } state_t;

    state_t            state_q, state_d;
    logic              re_meta, re_sync, re_hist;
    logic              rise_c;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              rd_en_d;
    logic [7:0]        cmd_d;
    logic              cmd_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              frame_ok_d, frame_err_d;
    logic [1:0]        err_code_d;
    logic              busy_d;

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;

    // re_in comes from the receiver clock domain: two-flop sync, then edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            re_meta <= 1'b0;
            re_sync <= 1'b0;
            re_hist <= 1'b0;
        end else begin
            re_meta <= re_in;
            re_sync <= re_meta;
            re_hist <= re_sync;
        end
    end

    assign rise_c = re_sync & ~re_hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            csum_q      <= '0;
            rd_addr     <= ADDR_TOP;
            rd_en       <= 1'b0;
            cmd         <= '0;
            cmd_valid   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            csum_q      <= csum_d;
            rd_addr     <= rd_addr_d;
            rd_en       <= rd_en_d;
            cmd         <= cmd_d;
            cmd_valid   <= cmd_valid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_ok    <= frame_ok_d;
            frame_err   <= frame_err_d;
            err_code    <= err_code_d;
            busy        <= busy_d;
        end
    end

    // rd_en is raised on entry to RD so the RAM word lands during WAIT
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        csum_d      = csum_q;
        rd_addr_d   = rd_addr;
        rd_en_d     = 1'b0;
        cmd_d       = cmd;
        cmd_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code;
        busy_d      = busy;

        if ((state_q != S_IDLE) && rise_c) begin
            // A new frame arrived before this one drained: drop it outright
            state_d     = S_IDLE;
            rd_addr_d   = ADDR_TOP;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            frame_err_d = 1'b1;
            err_code_d  = ERR_OVERRUN;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_d    = 1'b0;
                    rd_addr_d = ADDR_TOP;
                    if (rise_c) begin
                        busy_d  = 1'b1;
                        idx_d   = '0;
                        sum_d   = '0;
                        rd_en_d = 1'b1;
                        state_d = S_RD;
                    end
                end

                S_RD: begin
                    state_d = S_WAIT;
                end

                S_WAIT: begin
                    if ((idx_q == '0) && (mem_data != SYNC_BYTE)) begin
                        state_d     = S_IDLE;
                        rd_addr_d   = ADDR_TOP;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_SYNC;
                    end else if (idx_q < IDX_PAY0) begin
                        if (idx_q == IDX_CMD) begin
                            cmd_d       = mem_data;
                            cmd_valid_d = 1'b1;
                        end
                        sum_d     = sum_q + mem_data;
                        idx_d     = idx_q + IDX_W'(1);
                        rd_addr_d = rd_addr - ADDR_W'(1);
                        rd_en_d   = 1'b1;
                        state_d   = S_RD;
                    end else if (idx_q < IDX_CSUM) begin
                        out_data_d  = mem_data;
                        out_valid_d = 1'b1;
                        out_last_d  = (idx_q == IDX_LAST_PAY);
                        sum_d       = sum_q + mem_data;
                        state_d     = S_OUT;
                    end else begin
                        csum_d  = mem_data;
                        state_d = S_CHECK;
                    end
                end

                S_OUT: begin
                    if (out_if.out_ready) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        idx_d       = idx_q + IDX_W'(1);
                        rd_addr_d   = rd_addr - ADDR_W'(1);
                        rd_en_d     = 1'b1;
                        state_d     = S_RD;
                    end
                end

                S_CHECK: begin
                    state_d   = S_IDLE;
                    rd_addr_d = ADDR_TOP;
                    if (csum_q == sum_q) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_reader.sv
// Randomised bench for uart_frame_reader: RAM model, frame builder and a
// negedge monitor feed per-scenario checks against the frame format rules.
module tb_uart_frame_reader;

    localparam int FL = 113;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       re_in;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] rd_addr;
    logic       rd_en;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    uart_frame_reader_if out_if ();

    uart_frame_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .re_in     (re_in),
        .mem_data  (mem_data),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .out_if    (out_if),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame buffer RAM: one-cycle read latency
    logic [7:0] mem [256];
    always @(posedge clk) if (rd_en) mem_data <= mem[rd_addr];

    logic [7:0] exp_frame [FL];

    // Monitor state
    logic [7:0] pay_q [$];
    bit         last_q [$];
    int         addr_q [$];
    int         cmdv_cnt, ok_cnt, err_cnt, viol, valid_cyc, stall_run, max_stall;
    logic [7:0] cmd_seen;
    logic [1:0] err_seen;
    logic [7:0] prev_data;
    bit         prev_last, prev_stalled;

    // Ready driver controls
    int hold_at    = -1;
    int stall_left = 0;
    bit rnd_ready  = 1'b0;

    always @(negedge clk) begin
        if (rd_en) begin
            addr_q.push_back(int'(rd_addr));
            if (rd_addr < 8'd1 || rd_addr > 8'(FL)) viol++;
            if (out_if.out_valid) viol++;
        end
        if (out_if.out_valid) begin
            valid_cyc++;
            if (prev_stalled && (out_if.out_data !== prev_data || out_if.out_last !== prev_last)) viol++;
            if (out_if.out_ready) begin
                pay_q.push_back(out_if.out_data);
                last_q.push_back(out_if.out_last);
                stall_run = 0;
            end else begin
                stall_run++;
                if (stall_run > max_stall) max_stall = stall_run;
            end
        end
        prev_stalled = out_if.out_valid && !out_if.out_ready;
        prev_data    = out_if.out_data;
        prev_last    = out_if.out_last;
        if (cmd_valid) begin
            cmdv_cnt++;
            cmd_seen = cmd;
        end
        if (frame_ok) ok_cnt++;
        if (frame_err) begin
            err_cnt++;
            err_seen = err_code;
        end
    end

    always @(posedge clk) begin
        #1;
        if (hold_at >= 0 && pay_q.size() >= hold_at) out_if.out_ready = 1'b0;
        else if (stall_left > 0 && pay_q.size() == 5 && out_if.out_valid) begin
            out_if.out_ready = 1'b0;
            stall_left--;
        end else if (rnd_ready) out_if.out_ready = 1'($urandom_range(0, 1));
        else out_if.out_ready = 1'b1;
    end

    task automatic clear_mon();
        pay_q.delete();
        last_q.delete();
        addr_q.delete();
        cmdv_cnt = 0; ok_cnt = 0; err_cnt = 0; viol = 0; valid_cyc = 0;
        stall_run = 0; max_stall = 0; prev_stalled = 1'b0;
        cmd_seen = 8'h00; err_seen = 2'd0;
    endtask

    // Byte i lives at address FL-i; checksum is the mod-256 sum of bytes 0..FL-2
    task automatic make_frame(input logic [7:0] c, input bit rand_pay, input bit bad_sync, input bit bad_csum);
        int s;
        s = 0;
        exp_frame[0] = bad_sync ? 8'h5A : 8'hA5;
        exp_frame[1] = c;
        for (int i = 2; i <= FL - 2; i++) exp_frame[i] = rand_pay ? 8'($urandom) : 8'(i - 2);
        for (int i = 0; i <= FL - 2; i++) s += int'(exp_frame[i]);
        exp_frame[FL-1] = 8'(s % 256) ^ (bad_csum ? 8'h01 : 8'h00);
        for (int i = 0; i < FL; i++) mem[FL - i] = exp_frame[i];
    endtask

    function automatic int pay_mismatches();
        int n;
        n = 0;
        for (int i = 0; i < pay_q.size(); i++) begin
            if (i > FL - 4) n++;
            else begin
                if (pay_q[i] !== exp_frame[i + 2]) n++;
                if (last_q[i] !== (i == FL - 4)) n++;
            end
        end
        return n;
    endfunction

    function automatic int addr_mismatches();
        int n;
        n = 0;
        for (int k = 0; k < addr_q.size(); k++) if (addr_q[k] != FL - k) n++;
        return n;
    endfunction

    task automatic start_frame();
        @(posedge clk); #1;
        re_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        re_in = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (ok_cnt + err_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (ok_cnt + err_cnt == 0) begin
            checks++; errors++;
            $display("FAIL frame_end_timeout: no frame_ok/frame_err within %0d cycles", budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; re_in = 1'b0; out_if.out_ready = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rd_addr !== 8'd113) begin errors++; $display("FAIL reset_rd_addr got %0d want 113", rd_addr); end
        checks++; if ({rd_en, busy, cmd_valid, frame_ok, frame_err} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {rd_en, busy, cmd_valid, frame_ok, frame_err}); end
        checks++; if ({cmd, err_code, out_if.out_valid, out_if.out_last} !== 12'h0) begin errors++; $display("FAIL reset_data got %h want 000", {cmd, err_code, out_if.out_valid, out_if.out_last}); end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (addr_q.size() !== 0) begin errors++; $display("FAIL idle_no_read got %0d reads want 0", addr_q.size()); end
    endtask

    task automatic test_good_frame();
        clear_mon(); rnd_ready = 1'b0;
        make_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        start_frame();
        wait_done(3000);
        checks++; if (cmdv_cnt !== 1) begin errors++; $display("FAIL good_cmd_valid got %0d pulses want 1", cmdv_cnt); end
        checks++; if (cmd_seen !== 8'h3C || cmd !== 8'h3C) begin errors++; $display("FAIL good_cmd got %h/%h want 3c", cmd_seen, cmd); end
        checks++; if (pay_q.size() !== FL - 3) begin errors++; $display("FAIL good_pay_len got %0d want %0d", pay_q.size(), FL - 3); end
        checks++; if (pay_mismatches() !== 0) begin errors++; $display("FAIL good_pay_data got %0d bad bytes want 0", pay_mismatches()); end
        checks++; if (ok_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL good_result got ok=%0d err=%0d want 1/0", ok_cnt, err_cnt); end
        checks++; if (addr_q.size() !== FL || addr_mismatches() !== 0) begin errors++; $display("FAIL good_reads got %0d reads %0d bad addr want %0d/0", addr_q.size(), addr_mismatches(), FL); end
        checks++; if (busy !== 1'b0 || viol !== 0) begin errors++; $display("FAIL good_tail got busy=%b viol=%0d want 0/0", busy, viol); end
    endtask

    task automatic test_bad_sync();
        clear_mon();
        make_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
        start_frame();
        wait_done(200);
        checks++; if (err_cnt !== 1 || err_seen !== 2'd1 || ok_cnt !== 0) begin errors++; $display("FAIL sync_err got err=%0d code=%0d ok=%0d want 1/1/0", err_cnt, err_seen, ok_cnt); end
        checks++; if (addr_q.size() !== 1) begin errors++; $display("FAIL sync_reads got %0d want 1", addr_q.size()); end
        checks++; if (cmdv_cnt !== 0 || valid_cyc !== 0) begin errors++; $display("FAIL sync_quiet got cmdv=%0d valid=%0d want 0/0", cmdv_cnt, valid_cyc); end
    endtask

    task automatic test_bad_checksum();
        clear_mon(); rnd_ready = 1'b1;
        make_frame(8'($urandom), 1'b1, 1'b0, 1'b1);
        start_frame();
        wait_done(3000);
        checks++; if (pay_q.size() !== FL - 3 || pay_mismatches() !== 0) begin errors++; $display("FAIL csum_pay got len=%0d bad=%0d want %0d/0", pay_q.size(), pay_mismatches(), FL - 3); end
        checks++; if (err_cnt !== 1 || err_seen !== 2'd2 || ok_cnt !== 0) begin errors++; $display("FAIL csum_err got err=%0d code=%0d ok=%0d want 1/2/0", err_cnt, err_seen, ok_cnt); end
    endtask

    task automatic test_backpressure();
        clear_mon(); rnd_ready = 1'b1; stall_left = 20;
        make_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        start_frame();
        wait_done(4000);
        checks++; if (max_stall < 20) begin errors++; $display("FAIL bp_stall got %0d cycles want >=20", max_stall); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", viol); end
        checks++; if (pay_q.size() !== FL - 3 || pay_mismatches() !== 0) begin errors++; $display("FAIL bp_pay got len=%0d bad=%0d want %0d/0", pay_q.size(), pay_mismatches(), FL - 3); end
        checks++; if (ok_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL bp_result got ok=%0d err=%0d want 1/0", ok_cnt, err_cnt); end
        stall_left = 0;
    endtask

    task automatic test_overrun();
        int n;
        int a0;
        clear_mon(); rnd_ready = 1'b0; hold_at = 40;
        make_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        start_frame();
        repeat (10) @(posedge clk);
        #1;
        re_in = 1'b0;
        n = 0;
        while (!(pay_q.size() == 40 && out_if.out_valid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (pay_q.size() !== 40 || out_if.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_reach got len=%0d valid=%b want 40/1", pay_q.size(), out_if.out_valid); end
        re_in = 1'b1;
        wait_done(20);
        checks++; if (err_cnt !== 1 || err_seen !== 2'd3 || ok_cnt !== 0) begin errors++; $display("FAIL ovr_err got err=%0d code=%0d ok=%0d want 1/3/0", err_cnt, err_seen, ok_cnt); end
        checks++; if (pay_q.size() !== 40 || pay_mismatches() !== 0) begin errors++; $display("FAIL ovr_pay got len=%0d bad=%0d want 40/0", pay_q.size(), pay_mismatches()); end
        checks++; if (out_if.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ovr_drop got valid=%b busy=%b want 0/0", out_if.out_valid, busy); end
        hold_at = -1;
        a0 = addr_q.size();
        repeat (10) @(posedge clk);
        #1;
        checks++; if (addr_q.size() !== a0 || busy !== 1'b0) begin errors++; $display("FAIL ovr_no_restart got reads=%0d busy=%b want %0d/0", addr_q.size(), busy, a0); end
        clear_mon();
        start_frame();
        wait_done(3000);
        checks++; if (addr_q.size() == 0 || addr_q[0] !== FL) begin errors++; $display("FAIL ovr_fresh_addr got %0d reads want first addr %0d", addr_q.size(), FL); end
        checks++; if (ok_cnt !== 1 || pay_q.size() !== FL - 3 || pay_mismatches() !== 0) begin errors++; $display("FAIL ovr_fresh got ok=%0d len=%0d bad=%0d", ok_cnt, pay_q.size(), pay_mismatches()); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        clear_mon(); rnd_ready = 1'b1;
        make_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        start_frame();
        n = 0;
        while (pay_q.size() < 20 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (rd_addr !== 8'd113) begin errors++; $display("FAIL rst_mid_addr got %0d want 113", rd_addr); end
        checks++; if ({rd_en, busy, cmd_valid, frame_ok, frame_err, out_if.out_valid, out_if.out_last} !== 7'b0 || cmd !== 8'h00 || err_code !== 2'd0) begin
            errors++; $display("FAIL rst_mid_outputs got flags=%b cmd=%h code=%0d want 0", {rd_en, busy, cmd_valid, frame_ok, frame_err, out_if.out_valid, out_if.out_last}, cmd, err_code);
        end
        checks++; if (ok_cnt + err_cnt !== 0) begin errors++; $display("FAIL rst_mid_pulses got %0d want 0", ok_cnt + err_cnt); end
        rst_n = 1'b1;
        clear_mon();
        wait_done(4000);
        checks++; if (ok_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL rst_restart got ok=%0d err=%0d want 1/0", ok_cnt, err_cnt); end
        checks++; if (pay_q.size() !== FL - 3 || pay_mismatches() !== 0 || addr_mismatches() !== 0) begin errors++; $display("FAIL rst_restart_data got len=%0d bad=%0d", pay_q.size(), pay_mismatches()); end
    endtask

    task automatic test_back_to_back();
        bit         bad;
        logic [7:0] c;
        rnd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            bad = 1'($urandom_range(0, 1));
            c   = 8'($urandom);
            make_frame(c, 1'b1, 1'b0, bad);
            start_frame();
            wait_done(4000);
            checks++; if (cmd_seen !== c || cmdv_cnt !== 1) begin errors++; $display("FAIL b2b_cmd[%0d] got %h x%0d want %h x1", k, cmd_seen, cmdv_cnt, c); end
            checks++; if (pay_q.size() !== FL - 3 || pay_mismatches() !== 0) begin errors++; $display("FAIL b2b_pay[%0d] got len=%0d bad=%0d", k, pay_q.size(), pay_mismatches()); end
            checks++; if (ok_cnt !== (bad ? 0 : 1) || err_cnt !== (bad ? 1 : 0) || (bad && err_seen !== 2'd2)) begin
                errors++; $display("FAIL b2b_result[%0d] got ok=%0d err=%0d code=%0d bad=%0d", k, ok_cnt, err_cnt, err_seen, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_sync();
        test_bad_checksum();
        test_backpressure();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
